// File: rtl/fe_mul_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared field
// multiplier. slave = arbiter view, master = requester/multiplier side.
interface fe_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 320
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_op_a;
  logic [NREQ*W-1:0] req_op_b;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_done;
  logic [W-1:0]      res;
  logic [W-1:0]      mul_op_a;
  logic [W-1:0]      mul_op_b;
  logic              mul_valid;
  logic [W-1:0]      mul_res;
  logic              mul_done;
  logic              busy;
  logic              spurious;

  modport slave (
    input  req_valid, req_op_a, req_op_b, mul_res, mul_done,
    output req_ack, req_done, res, mul_op_a, mul_op_b, mul_valid, busy, spurious
  );

  modport master (
    output req_valid, req_op_a, req_op_b, mul_res, mul_done,
    input  req_ack, req_done, res, mul_op_a, mul_op_b, mul_valid, busy, spurious
  );
endinterface

// File: rtl/fe_mul_arbiter.sv
// Round-robin arbiter sharing one field multiplier among NREQ requesters.
// One multiply in flight at a time; operands are latched at grant and held
// until the multiplier reports completion.
module fe_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 320
) (
  input  logic            clk,
  input  logic            rst,
  fe_mul_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] owner_nxt;
  logic [PW-1:0] win;
  logic          any_req;

  // Index base+k, wrapped back into 0..NREQ-1.
  function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  assign owner_nxt = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

  // First active requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_req && bus.req_valid[rot(rr_ptr, k)]) begin
        any_req = 1'b1;
        win     = rot(rr_ptr, k);
      end
    end
  end

  // Grant/complete FSM; every output is a register so pulses are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      bus.req_ack  <= '0;
      bus.req_done <= '0;
      bus.mul_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.spurious <= 1'b0;
      bus.res      <= '0;
      bus.mul_op_a <= '0;
      bus.mul_op_b <= '0;
    end else begin
      bus.req_ack   <= '0;
      bus.req_done  <= '0;
      bus.mul_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A completion with nothing in flight (e.g. one orphaned by reset)
          // carries no owner; only flag it.
          if (bus.mul_done) bus.spurious <= 1'b1;
          if (any_req) begin
            bus.mul_op_a  <= bus.req_op_a[int'(win)*W +: W];
            bus.mul_op_b  <= bus.req_op_b[int'(win)*W +: W];
            bus.mul_valid <= 1'b1;
            bus.req_ack   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            owner         <= win;
            bus.busy      <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // Requests are not looked at here; completion may arrive as early as
          // the cycle mul_valid is high.
          if (bus.mul_done) begin
            bus.res      <= bus.mul_res;
            bus.req_done <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
            rr_ptr       <= owner_nxt;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Bench for fe_mul_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a transaction
// level model (outstanding flag, last-served index, rotating search).
module tb_fe_mul_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 320;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fe_mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus();
  fe_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int           m_last, m_owner;
  bit           m_out;
  int           e_ack, e_done;
  bit           e_mulv, e_spur;
  logic [W-1:0] e_res, e_opa, e_opb;

  task automatic model_reset();
    m_last = NREQ - 1; m_owner = 0; m_out = 0;
    e_ack = -1; e_done = -1; e_mulv = 0; e_spur = 0;
    e_res = '0; e_opa = '0; e_opb = '0;
  endtask

  task automatic model_step();
    int  c;
    bit  got;
    e_ack = -1; e_done = -1; e_mulv = 0;
    if (m_out) begin
      if (bus.mul_done) begin
        e_res = bus.mul_res; e_done = m_owner; m_last = m_owner; m_out = 0;
      end
    end else begin
      if (bus.mul_done) e_spur = 1;
      got = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (!got && bus.req_valid[c]) begin
          got = 1; e_ack = c; e_mulv = 1; m_owner = c; m_out = 1;
          e_opa = bus.req_op_a[c*W +: W];
          e_opb = bus.req_op_b[c*W +: W];
        end
      end
    end
  endtask

  // compare current outputs, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("m_ack",  W'(bus.req_ack),   W'(oh(e_ack)));
    chk("m_done", W'(bus.req_done),  W'(oh(e_done)));
    chk("m_mulv", W'(bus.mul_valid), W'(e_mulv));
    chk("m_busy", W'(bus.busy),      W'(m_out));
    chk("m_spur", W'(bus.spurious),  W'(e_spur));
    chk("m_res",  bus.res,           e_res);
    chk("m_opa",  bus.mul_op_a,      e_opa);
    chk("m_opb",  bus.mul_op_b,      e_opb);
    if (rst) model_step();
  end

  // ---------------- environment ----------------
  int lat, cnt;
  bit pend, rand_lat, rand_en;

  // one cycle: requesters drop on ack, multiplier counts latency, optional random requests
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) bus.req_valid[i] = 1'b0;
    bus.mul_done = 1'b0;
    if (bus.mul_valid) begin
      pend = 1;
      cnt  = rand_lat ? int'($urandom_range(0, 4)) : lat;
    end
    if (pend) begin
      if (cnt == 0) begin
        pend = 0;
        bus.mul_done = 1'b1;
        bus.mul_res  = bus.mul_op_a * bus.mul_op_b;
      end else cnt--;
    end
    if (rand_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && !bus.req_ack[i]) begin
          bus.req_op_a[i*W +: W] = rnd_w();
          bus.req_op_b[i*W +: W] = rnd_w();
          if ($urandom_range(0, 2) == 0) bus.req_valid[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (bus.req_valid == '0 && !bus.busy && !pend) break;
      step();
    end
    chk("drain_idle", W'(bus.busy), W'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[5];
    int ng;
    bus.req_valid = '0; bus.req_op_a = '0; bus.req_op_b = '0;
    bus.mul_res = '0; bus.mul_done = 1'b0;
    lat = 1; cnt = 0; pend = 0; rand_lat = 0; rand_en = 0;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_res",  bus.res, W'(0));
    chk("rst_opa",  bus.mul_op_a, W'(0));
    chk("rst_spur", W'(bus.spurious), W'(0));
    rst = 1'b1;
    step();

    // single request, latency 4, operand change after ack
    lat = 4;
    bus.req_op_a[2*W +: W] = W'(3);
    bus.req_op_b[2*W +: W] = W'(5);
    bus.req_valid = 4'b0100;
    step();
    chk("s_ack",  W'(bus.req_ack), W'(4'b0100));
    chk("s_mulv", W'(bus.mul_valid), W'(1));
    chk("s_opa",  bus.mul_op_a, W'(3));
    chk("s_opb",  bus.mul_op_b, W'(5));
    bus.req_op_a[2*W +: W] = W'(7);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s_nodone", W'(bus.req_done), W'(0));
      chk("s_hold_a", bus.mul_op_a, W'(3));
    end
    step();
    chk("s_done", W'(bus.req_done), W'(4'b0100));
    chk("s_res",  bus.res, W'(15));
    chk("s_busy", W'(bus.busy), W'(0));

    // mul_done while idle
    bus.mul_done = 1'b1;
    bus.mul_res  = W'(99);
    step();
    chk("sp_flag", W'(bus.spurious), W'(1));
    chk("sp_res",  bus.res, W'(15));
    chk("sp_done", W'(bus.req_done), W'(0));
    step();
    chk("sp_sticky", W'(bus.spurious), W'(1));
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("sp_clr", W'(bus.spurious), W'(0));

    // latency-0 multiplier and immediate re-grant
    lat = 0;
    bus.req_op_a[1*W +: W] = W'(11); bus.req_op_b[1*W +: W] = W'(13);
    bus.req_valid = 4'b0010;
    step();
    chk("z_ack", W'(bus.req_ack), W'(4'b0010));
    bus.req_op_a[3*W +: W] = W'(2); bus.req_op_b[3*W +: W] = W'(9);
    bus.req_valid[3] = 1'b1;
    step();
    chk("z_done", W'(bus.req_done), W'(4'b0010));
    chk("z_res",  bus.res, W'(143));
    chk("z_noack", W'(bus.req_ack), W'(0));
    chk("z_idle", W'(bus.busy), W'(0));
    step();
    chk("z_ack2", W'(bus.req_ack), W'(4'b1000));
    step();
    chk("z_done2", W'(bus.req_done), W'(4'b1000));
    chk("z_res2",  bus.res, W'(18));

    // contention: all four held, re-asserted after each done
    lat = 1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op_a[i*W +: W] = W'(i + 1);
      bus.req_op_b[i*W +: W] = W'(i + 100);
    end
    bus.req_valid = '1;
    ng = 0;
    for (int n = 0; n < 60 && ng < 5; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (bus.req_ack[i] && ng < 5) begin grants[ng] = i; ng++; end
      if (ng >= 5) bus.req_valid = '0;
      else if (bus.req_done != '0) bus.req_valid = '1;
    end
    chk("c_count", W'(ng), W'(5));
    for (int g = 0; g < 5; g++) chk($sformatf("c_grant%0d", g), W'(grants[g]), W'(g % NREQ));
    drain();

    // reset during WAIT, orphaned completion afterwards
    lat = 5;
    bus.req_valid = 4'b0100;
    step();
    chk("r_ack", W'(bus.req_ack), W'(4'b0100));
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("r_busy", W'(bus.busy), W'(0));
    chk("r_mulv", W'(bus.mul_valid), W'(0));
    chk("r_opa",  bus.mul_op_a, W'(0));
    chk("r_res",  bus.res, W'(0));
    step();
    rst = 1'b1;
    step(); step(); step();
    chk("r_spur", W'(bus.spurious), W'(1));
    chk("r_nodone", W'(bus.req_done), W'(0));
    bus.req_valid = 4'b1010;
    step();
    chk("r_low", W'(bus.req_ack), W'(4'b0010));
    drain();

    // randomized traffic
    rst = 1'b0;
    step();
    rst = 1'b1;
    rand_lat = 1; rand_en = 1;
    repeat (3000) step();
    rand_en = 0;
    drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
